maze_key_decoder: RTL and testbench

Converts the raw PS/2 Set-2 scan-code byte stream from the keyboard receiver into clean one-cycle direction pulses for the character mover. It handles E0 (extended) and F0 (break) prefixes and tracks which direction keys are held. While a key stays held it generates its own auto-repeat at a fixed, configurable rate, so movement speed does not depend on the keyboard's typematic rate. It sits between `kb_code` and `maze_move`.

---
 rtl/maze_pkg.sv | 58 +++++
 rtl/maze_repeat_timer.sv | 38 +++
 rtl/maze_key_decoder.sv | 131 +++++++++++++
 tb/tb_maze_key_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants for the maze keyboard path: direction indices, PS/2 Set-2 codes, prefix FSM states.
// MAZE_KEY_WASD_EN adds the WASD keys to the direction decode.
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef logic [1:0] pfx_state_t;
  localparam pfx_state_t ST_IDLE    = 2'd0;
  localparam pfx_state_t ST_EXT     = 2'd1;
  localparam pfx_state_t ST_BRK     = 2'd2;
  localparam pfx_state_t ST_EXT_BRK = 2'd3;

  // Returns {hit, idx}; hit is 0 for any code that is not a direction key of the given extended-ness.
  function automatic logic [2:0] decode_dir(input logic [7:0] code, input logic ext);
    logic [2:0] r;
    r = 3'b000;
    if (ext) begin
      case (code)
        SC_UP:    r = {1'b1, DIR_UP};
        SC_DOWN:  r = {1'b1, DIR_DOWN};
        SC_LEFT:  r = {1'b1, DIR_LEFT};
        SC_RIGHT: r = {1'b1, DIR_RIGHT};
        default:  r = 3'b000;
      endcase
    end
`ifdef MAZE_KEY_WASD_EN
    else begin
      case (code)
        SC_W:    r = {1'b1, DIR_UP};
        SC_S:    r = {1'b1, DIR_DOWN};
        SC_A:    r = {1'b1, DIR_LEFT};
        SC_D:    r = {1'b1, DIR_RIGHT};
        default: r = 3'b000;
      endcase
    end
`endif
    return r;
  endfunction

  function automatic logic [3:0] dir_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/maze_repeat_timer.sv
// Auto-repeat counter: load arms REPEAT_DELAY, then expire pulses every REPEAT_RATE while run.
// expire is combinational and lasts one cycle; enable low holds the counter at REPEAT_DELAY.
module maze_repeat_timer #(
  parameter int REPEAT_DELAY = 20_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int CNT_W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  assign expire = enable && run && (cnt == CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || load) begin
      cnt <= DELAY_LD;
    end else if (run) begin
      if (cnt == CNT_ONE) begin
        cnt <= RATE_LD;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/maze_key_decoder.sv
// PS/2 Set-2 bytes to one-cycle direction pulses with held-key tracking and fixed-rate auto-repeat.
// dir_pulse is registered (one cycle after the final byte); MAZE_KEY_WASD_EN adds WASD keys.
module maze_key_decoder
  import maze_pkg::*;
#(
  parameter int REPEAT_DELAY = 20_000_000,
  parameter int REPEAT_RATE  = 5_000_000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [3:0] dir_pulse,
  output logic [3:0] held,
  output logic [2:0] active_dir
);

  pfx_state_t state, state_nxt;
  logic       ev_make, ev_brk, ev_ext;
  logic [2:0] dec;
  logic       key_hit;
  logic [1:0] key_idx;
  logic       make_new, brk_held, brk_active;
  logic       expire;

  always_comb begin
    state_nxt = state;
    ev_make   = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_EXT) begin
            state_nxt = ST_EXT;
          end else if (scan_code == SC_BRK) begin
            state_nxt = ST_BRK;
          end else begin
            ev_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code == SC_BRK) begin
            state_nxt = ST_EXT_BRK;
          end else begin
            ev_make   = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_brk    = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          ev_brk    = 1'b1;
          ev_ext    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign dec     = decode_dir(scan_code, ev_ext);
  assign key_hit = dec[2];
  assign key_idx = dec[1:0];

  // A make of an already-held key is keyboard typematic and must not restart anything.
  assign make_new   = ev_make && key_hit && !held[key_idx];
  assign brk_held   = ev_brk && key_hit && held[key_idx];
  assign brk_active = brk_held && active_dir[2] && (active_dir[1:0] == key_idx);

  maze_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (make_new),
    .run    (active_dir[2]),
    .enable (enable),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held       <= 4'b0000;
      active_dir <= 3'b000;
    end else begin
      if (make_new) begin
        held[key_idx] <= 1'b1;
        active_dir    <= {1'b1, key_idx};
      end else if (brk_held) begin
        held[key_idx] <= 1'b0;
        if (brk_active) begin
          active_dir <= 3'b000;
        end
      end
    end
  end

  // New make beats a coinciding expiry; a break of the active key cancels it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_pulse <= 4'b0000;
    end else if (!enable) begin
      dir_pulse <= 4'b0000;
    end else if (make_new) begin
      dir_pulse <= dir_onehot(key_idx);
    end else if (expire && !brk_active) begin
      dir_pulse <= dir_onehot(active_dir[1:0]);
    end else begin
      dir_pulse <= 4'b0000;
    end
  end

  assert property (@(posedge clk) disable iff (reset) $onehot0(dir_pulse));

endmodule

// File: tb/tb_maze_key_decoder.sv
// Directed bench for maze_key_decoder with REPEAT_DELAY=10, REPEAT_RATE=4; honours MAZE_KEY_WASD_EN.
module tb_maze_key_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [3:0] dir_pulse;
  logic [3:0] held;
  logic [2:0] active_dir;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  maze_key_decoder #(
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (4),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .dir_pulse  (dir_pulse),
    .held       (held),
    .active_dir (active_dir)
  );

  typedef struct packed {
    logic       vld;
    logic       en;
    logic [7:0] code;
    logic [3:0] pulse;
    logic [3:0] hld;
    logic [2:0] act;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vld, input logic en, input logic [7:0] code,
                     input logic [3:0] pulse, input logic [3:0] hld, input logic [2:0] act);
    vec_t v;
    v.vld = vld; v.en = en; v.code = code; v.pulse = pulse; v.hld = hld; v.act = act;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] p, input logic [3:0] h, input logic [2:0] a);
    chk({name, ".pulse"}, {4'h0, dir_pulse}, {4'h0, p});
    chk({name, ".held"}, {4'h0, held}, {4'h0, h});
    chk({name, ".active"}, {5'h0, active_dir}, {5'h0, a});
  endtask

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    scan_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Checks dir_pulse for n cycles; exp_k lists the only cycles that carry exp_p.
  task automatic watch(input string name, input int n, input int first, input int period,
                       input logic [3:0] exp_p);
    for (int k = 1; k <= n; k++) begin
      logic [3:0] e;
      @(negedge clk);
      e = 4'b0000;
      if (first > 0 && k >= first && ((k - first) % period) == 0) e = exp_p;
      chk($sformatf("%s_k%0d", name, k), {4'h0, dir_pulse}, {4'h0, e});
    end
  endtask

  initial begin
    logic [3:0] wp, wh;
    logic [2:0] wa;
`ifdef MAZE_KEY_WASD_EN
    wp = 4'b0100; wh = 4'b0100; wa = 3'b110;
`else
    wp = 4'b0000; wh = 4'b0000; wa = 3'b000;
`endif

    // reset values
    @(negedge clk);
    chk_all("reset", 4'b0000, 4'b0000, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // {vld, en, code, pulse, held, active}
    add(1, 1, 8'hE0, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'h75, 4'b0001, 4'b0001, 3'b100);
    add(1, 1, 8'hE0, 4'b0000, 4'b0001, 3'b100);
    add(1, 1, 8'h75, 4'b0000, 4'b0001, 3'b100);
    add(1, 1, 8'hE0, 4'b0000, 4'b0001, 3'b100);
    add(1, 1, 8'h74, 4'b1000, 4'b1001, 3'b111);
    add(1, 1, 8'hE0, 4'b0000, 4'b1001, 3'b111);
    add(1, 1, 8'hF0, 4'b0000, 4'b1001, 3'b111);
    add(1, 1, 8'h74, 4'b0000, 4'b0001, 3'b000);
    add(1, 1, 8'hE0, 4'b0000, 4'b0001, 3'b000);
    add(1, 1, 8'hF0, 4'b0000, 4'b0001, 3'b000);
    add(1, 1, 8'h75, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'h1C, wp,      wh,      wa);
    add(1, 1, 8'hF0, 4'b0000, wh,      wa);
    add(1, 1, 8'h1C, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'hE0, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'hF0, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'h6B, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'h6B, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'hE0, 4'b0000, 4'b0000, 3'b000);
    add(1, 1, 8'h1D, 4'b0000, 4'b0000, 3'b000);
    add(1, 0, 8'hE0, 4'b0000, 4'b0000, 3'b000);
    add(1, 0, 8'h72, 4'b0000, 4'b0010, 3'b101);
    add(0, 1, 8'h00, 4'b0000, 4'b0010, 3'b101);
    add(1, 1, 8'hE0, 4'b0000, 4'b0010, 3'b101);
    add(1, 1, 8'hF0, 4'b0000, 4'b0010, 3'b101);
    add(1, 1, 8'h72, 4'b0000, 4'b0000, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      enable     = tbl[i].en;
      scan_valid = tbl[i].vld;
      scan_code  = tbl[i].code;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].pulse, tbl[i].hld, tbl[i].act);
    end
    scan_valid = 1'b0;
    enable = 1'b1;

    // Repeat cadence: 10 cycles to the first repeat, then every 4; break stops it.
    do_reset();
    send(8'hE0); send(8'h75);
    chk_all("rep_first", 4'b0001, 4'b0001, 3'b100);
    watch("rep", 30, 10, 4, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk_all("rep_brk", 4'b0000, 4'b0000, 3'b000);
    watch("rep_after", 20, 0, 1, 4'b0000);

    // Right overrides up; release of right coincides with its expiry.
    do_reset();
    send(8'hE0); send(8'h75);
    @(negedge clk); @(negedge clk);
    send(8'hE0); send(8'h74);
    chk_all("ovr_first", 4'b1000, 4'b1001, 3'b111);
    watch("ovr", 15, 10, 4, 4'b1000);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk_all("ovr_brk_exp", 4'b0000, 4'b0001, 3'b000);
    watch("ovr_after", 20, 0, 1, 4'b0000);

    // New make on the very cycle the active key would repeat.
    do_reset();
    send(8'hE0); send(8'h75);
    watch("mkexp_pre", 8, 0, 1, 4'b0000);
    send(8'hE0); send(8'h74);
    chk_all("mkexp", 4'b1000, 4'b1001, 3'b111);
    watch("mkexp_post", 10, 10, 4, 4'b1000);

    // enable low suppresses pulses; raising it restarts the delay.
    do_reset();
    enable = 1'b0;
    send(8'hE0); send(8'h75);
    chk_all("en0", 4'b0000, 4'b0001, 3'b100);
    watch("en0_hold", 15, 0, 1, 4'b0000);
    enable = 1'b1;
    watch("en1", 12, 10, 4, 4'b0001);

    // Reset in the middle of an extended sequence.
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0);
    reset = 1'b1;
    @(negedge clk);
    chk_all("mid_rst", 4'b0000, 4'b0000, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    send(8'h6B);
    chk_all("post_rst_6b", 4'b0000, 4'b0000, 3'b000);
    send(8'h1C);
    chk_all("post_rst_1c", wp, wh, wa);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
